// File: rtl/fetch_stage.sv
`default_nettype none
// fetch_stage: PC, single-outstanding imem request, IF/ID register and a
// one-entry buffer for a response that lands while ID is stalled. Rev 1.0
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        PCWrite_i,
  input  logic        Stall_i,
  input  logic        Flush_i,
  input  logic [31:0] BranchTarget_i,
  output logic        IMemReq_o,
  output logic [31:0] IMemAddr_o,
  input  logic        IMemValid_i,
  input  logic [31:0] IMemData_i,
  output logic [31:0] IDPC_o,
  output logic [31:0] IDInstr_o,
  output logic        IDValid_o,
  output logic        FetchBusy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic        req, req_nxt;
  logic        drop, drop_nxt;
  logic [31:0] id_pc, id_pc_nxt;
  logic [31:0] id_instr, id_instr_nxt;
  logic        id_valid, id_valid_nxt;
  logic [31:0] buf_pc, buf_pc_nxt;
  logic [31:0] buf_instr, buf_instr_nxt;
  logic        advance;

  assign advance = PCWrite_i & ~Stall_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      req       <= 1'b0;
      drop      <= 1'b0;
      id_pc     <= 32'h0;
      id_instr  <= NOP_INSTR;
      id_valid  <= 1'b0;
      buf_pc    <= 32'h0;
      buf_instr <= NOP_INSTR;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      req_addr  <= req_addr_nxt;
      req       <= req_nxt;
      drop      <= drop_nxt;
      id_pc     <= id_pc_nxt;
      id_instr  <= id_instr_nxt;
      id_valid  <= id_valid_nxt;
      buf_pc    <= buf_pc_nxt;
      buf_instr <= buf_instr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    req_addr_nxt  = req_addr;
    req_nxt       = req;
    drop_nxt      = drop;
    id_pc_nxt     = id_pc;
    id_instr_nxt  = id_instr;
    id_valid_nxt  = id_valid;
    buf_pc_nxt    = buf_pc;
    buf_instr_nxt = buf_instr;

    case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt    = FETCH;
          req_nxt      = 1'b1;
          req_addr_nxt = pc;
        end
      end

      FETCH: begin
        if (Flush_i) begin
          id_instr_nxt = NOP_INSTR;
          id_valid_nxt = 1'b0;
          pc_nxt       = BranchTarget_i;
          if (IMemValid_i) begin
            drop_nxt     = 1'b0;
            req_nxt      = 1'b1;
            req_addr_nxt = BranchTarget_i;
          end else begin
            // Request must stay stable until memory answers; kill it on return.
            drop_nxt = 1'b1;
          end
        end else if (IMemValid_i) begin
          if (drop) begin
            drop_nxt     = 1'b0;
            req_nxt      = 1'b1;
            req_addr_nxt = pc;
            if (advance) begin
              id_instr_nxt = NOP_INSTR;
              id_valid_nxt = 1'b0;
            end
          end else if (advance) begin
            id_pc_nxt    = req_addr;
            id_instr_nxt = IMemData_i;
            id_valid_nxt = 1'b1;
            pc_nxt       = pc + 32'd4;
            req_addr_nxt = pc + 32'd4;
            req_nxt      = 1'b1;
          end else begin
            buf_pc_nxt    = req_addr;
            buf_instr_nxt = IMemData_i;
            req_nxt       = 1'b0;
            state_nxt     = HOLD;
          end
        end else if (advance) begin
          id_instr_nxt = NOP_INSTR;
          id_valid_nxt = 1'b0;
        end
      end

      HOLD: begin
        if (Flush_i) begin
          id_instr_nxt  = NOP_INSTR;
          id_valid_nxt  = 1'b0;
          buf_instr_nxt = NOP_INSTR;
          pc_nxt        = BranchTarget_i;
          req_nxt       = 1'b1;
          req_addr_nxt  = BranchTarget_i;
          state_nxt     = FETCH;
        end else if (advance) begin
          id_pc_nxt     = buf_pc;
          id_instr_nxt  = buf_instr;
          id_valid_nxt  = 1'b1;
          buf_instr_nxt = NOP_INSTR;
          pc_nxt        = pc + 32'd4;
          req_addr_nxt  = pc + 32'd4;
          req_nxt       = 1'b1;
          state_nxt     = FETCH;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign IMemReq_o   = req;
  assign IMemAddr_o  = req_addr;
  assign IDPC_o      = id_pc;
  assign IDInstr_o   = id_instr;
  assign IDValid_o   = id_valid;
  assign FetchBusy_o = (state == FETCH) | (state == HOLD);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// tb_fetch_stage: random stall/flush/latency stimulus; the ID-side stream is
// predicted from sequential-PC and redirect rules and checked by a monitor.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        PCWrite_i = 1'b1;
  logic        Stall_i = 1'b0;
  logic        Flush_i = 1'b0;
  logic [31:0] BranchTarget_i = 32'h0;
  logic        IMemValid_i = 1'b0;
  logic [31:0] IMemData_i = 32'h0;
  logic        IMemReq_o, IDValid_o, FetchBusy_o;
  logic [31:0] IMemAddr_o, IDPC_o, IDInstr_o;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .PCWrite_i(PCWrite_i), .Stall_i(Stall_i), .Flush_i(Flush_i),
    .BranchTarget_i(BranchTarget_i),
    .IMemReq_o(IMemReq_o), .IMemAddr_o(IMemAddr_o),
    .IMemValid_i(IMemValid_i), .IMemData_i(IMemData_i),
    .IDPC_o(IDPC_o), .IDInstr_o(IDInstr_o), .IDValid_o(IDValid_o),
    .FetchBusy_o(FetchBusy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: ID sees consecutive words from the start PC, restarting at each redirect.
  logic [31:0] exp_q[$];
  logic [31:0] nxt_pc = RESET_PC;
  bit          running = 0;
  bit          loaded = 0;

  initial forever begin
    @(posedge clk_i);
    if (!rst_i) begin
      running = 0;
      loaded  = 0;
      exp_q.delete();
    end else begin
      if (!running && start_i) begin
        running = 1;
        nxt_pc  = RESET_PC;
      end else if (running && Flush_i) begin
        exp_q.delete();
        nxt_pc = BranchTarget_i;
      end
      if (running)
        while (exp_q.size() < 4) begin
          exp_q.push_back(nxt_pc);
          nxt_pc = nxt_pc + 32'd4;
        end
      loaded = (PCWrite_i && !Stall_i) || Flush_i;
    end
  end

  // Monitor: compares each freshly loaded IF/ID value against the scoreboard.
  logic [31:0] p_pc = 32'h0, p_instr = NOP;
  logic        p_valid = 1'b0;

  initial forever begin
    @(negedge clk_i);
    if (!rst_i) begin
      p_pc = 32'h0; p_instr = NOP; p_valid = 1'b0;
      continue;
    end
    if (loaded) begin
      if (IDValid_o) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty actual=pc %h required=no instruction", IDPC_o);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("id_pc", IDPC_o, e);
          check("id_instr", IDInstr_o, mem_word(e));
          delivered++;
        end
      end else begin
        check("bubble_instr", IDInstr_o, NOP);
      end
    end else begin
      check("hold_pc", IDPC_o, p_pc);
      check("hold_instr", IDInstr_o, p_instr);
      check("hold_valid", {31'h0, IDValid_o}, {31'h0, p_valid});
    end
    p_pc = IDPC_o; p_instr = IDInstr_o; p_valid = IDValid_o;
  end

  // Memory: single outstanding request, latency fixed or random 1..3.
  bit          mem_en = 1;
  bit          pending = 0;
  int          lat_fixed = 1;
  int          cnt = 0;
  logic [31:0] cap = 32'h0;

  initial forever begin
    @(posedge clk_i); #1;
    if (!mem_en) continue;
    if (!rst_i) begin
      pending = 0; IMemValid_i = 1'b0;
      continue;
    end
    if (IMemValid_i) begin
      IMemValid_i = 1'b0;
      pending = 0;
    end
    IMemData_i = $urandom;
    if (!pending) begin
      if (IMemReq_o) begin
        pending = 1;
        cap = IMemAddr_o;
        cnt = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 3));
      end
    end else begin
      check("req_held", {31'h0, IMemReq_o}, 32'h1);
      check("addr_stable", IMemAddr_o, cap);
      cnt--;
      if (cnt == 0) begin
        IMemValid_i = 1'b1;
        IMemData_i  = mem_word(cap);
      end
    end
  end

  task automatic step();
    @(posedge clk_i); #2;
  endtask

  task automatic wait_for(input int kind, input string name);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      step();
      case (kind)
        0:       ok = FetchBusy_o && !IMemReq_o;
        1:       ok = IMemReq_o && !IMemValid_i && pending;
        default: ok = IMemReq_o;
      endcase
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=timeout required=condition within 60 cycles", name);
    end
  endtask

  initial begin
    repeat (2) step();
    check("rst_req", {31'h0, IMemReq_o}, 32'h0);
    check("rst_addr", IMemAddr_o, RESET_PC);
    check("rst_idpc", IDPC_o, 32'h0);
    check("rst_instr", IDInstr_o, NOP);
    check("rst_valid", {31'h0, IDValid_o}, 32'h0);
    check("rst_busy", {31'h0, FetchBusy_o}, 32'h0);

    rst_i = 1'b1;
    step();
    check("idle_req", {31'h0, IMemReq_o}, 32'h0);
    start_i = 1'b1;
    step();
    check("start_req", {31'h0, IMemReq_o}, 32'h1);
    check("start_addr", IMemAddr_o, RESET_PC);
    check("start_busy", {31'h0, FetchBusy_o}, 32'h1);
    repeat (12) step();

    lat_fixed = 3;
    repeat (20) step();

    // Stall into HOLD, then release.
    Stall_i = 1'b1; PCWrite_i = 1'b0;
    wait_for(0, "reach_hold");
    check("hold_req", {31'h0, IMemReq_o}, 32'h0);
    repeat (2) step();
    Stall_i = 1'b0; PCWrite_i = 1'b1;
    step();
    check("release_valid", {31'h0, IDValid_o}, 32'h1);
    check("release_req", {31'h0, IMemReq_o}, 32'h1);
    check("release_addr", IMemAddr_o, IDPC_o + 32'd4);
    repeat (6) step();

    // Flush while a request is outstanding.
    wait_for(1, "outstanding_req");
    Flush_i = 1'b1; BranchTarget_i = 32'h0000_0100;
    step();
    Flush_i = 1'b0;
    check("flush_bubble", {31'h0, IDValid_o}, 32'h0);
    repeat (15) step();

    // Flush together with stall while in HOLD.
    Stall_i = 1'b1; PCWrite_i = 1'b0;
    wait_for(0, "reach_hold2");
    Flush_i = 1'b1; BranchTarget_i = 32'h0000_0200;
    step();
    Flush_i = 1'b0; Stall_i = 1'b0; PCWrite_i = 1'b1;
    check("hflush_valid", {31'h0, IDValid_o}, 32'h0);
    check("hflush_req", {31'h0, IMemReq_o}, 32'h1);
    check("hflush_addr", IMemAddr_o, 32'h0000_0200);
    repeat (10) step();

    // Random phase, including redirects that wrap the address space.
    lat_fixed = 0;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      Stall_i   = (r < 20);
      PCWrite_i = (r < 20) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) != 0);
      Flush_i   = ($urandom_range(0, 99) < 4);
      BranchTarget_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      step();
    end
    Flush_i = 1'b0; Stall_i = 1'b0; PCWrite_i = 1'b1;
    repeat (8) step();

    // Reset mid-request; a stale response in IDLE must be ignored.
    wait_for(2, "req_before_reset");
    rst_i = 1'b0; start_i = 1'b0; mem_en = 0; pending = 0; IMemValid_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    IMemValid_i = 1'b1; IMemData_i = 32'hDEAD_BEEF;
    step();
    IMemValid_i = 1'b0;
    check("stale_valid", {31'h0, IDValid_o}, 32'h0);
    check("stale_req", {31'h0, IMemReq_o}, 32'h0);
    check("stale_busy", {31'h0, FetchBusy_o}, 32'h0);
    start_i = 1'b1; mem_en = 1;
    step();
    check("restart_req", {31'h0, IMemReq_o}, 32'h1);
    check("restart_addr", IMemAddr_o, RESET_PC);
    repeat (20) step();

    checks++;
    if (delivered < 100) begin
      errors++;
      $display("FAIL progress actual=%0d required>=100 instructions", delivered);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
